// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
// Also holds a helper that sizes the starvation counter.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int MEM_MASK_W = 8;

    typedef logic [1:0] arb_state_t;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// LSU-priority pick with a starvation override for a waiting IFU.
// Purely combinational; the caller gates the result with its IDLE state.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             ifu_req,
    input  logic             lsu_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_ifu,
    output logic             grant_lsu
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    always_comb begin
        grant_lsu = lsu_req && (!ifu_req || (starve_cnt < STARVE_LIM));
        grant_ifu = ifu_req && !grant_lsu;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (IFU) and load/store (LSU),
// one transaction at a time, with fetch-flush response dropping.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req,
    input  logic [ADDR_W-1:0]     ifu_addr,
    input  logic                  ifu_flush,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [MEM_MASK_W-1:0] lsu_wmask,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int               CNT_W      = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic                  owner;
    logic                  drop;
    logic [CNT_W-1:0]      starve_cnt;
    logic [ADDR_W-1:0]     cap_addr;
    logic                  cap_wen;
    logic [DATA_W-1:0]     cap_wdata;
    logic [MEM_MASK_W-1:0] cap_wmask;

    logic grant_ifu;
    logic grant_lsu;
    logic in_idle;
    logic in_req;
    logic resp_fire;

    arb_prio #(
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) u_prio (
        .ifu_req   (ifu_req),
        .lsu_req   (lsu_req),
        .starve_cnt(starve_cnt),
        .grant_ifu (grant_ifu),
        .grant_lsu (grant_lsu)
    );

    assign in_idle = (state == ARB_IDLE);
    assign in_req  = (state == ARB_REQ);

    // A response counts in RESP, or in REQ when it arrives together with mem_gnt.
    assign resp_fire = mem_rvalid && ((state == ARB_RESP) || (in_req && mem_gnt));

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant_ifu || grant_lsu) state_nxt = ARB_REQ;
            ARB_REQ:  if (mem_gnt) state_nxt = mem_rvalid ? ARB_IDLE : ARB_RESP;
            ARB_RESP: if (mem_rvalid) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IFU;
            drop       <= 1'b0;
            starve_cnt <= '0;
            cap_addr   <= '0;
            cap_wen    <= 1'b0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
        end else begin
            state <= state_nxt;
            if (in_idle && grant_lsu) begin
                owner     <= OWN_LSU;
                cap_addr  <= lsu_addr;
                cap_wen   <= lsu_wen;
                cap_wdata <= lsu_wdata;
                cap_wmask <= lsu_wmask;
                if (!ifu_req)
                    starve_cnt <= '0;
                else if (starve_cnt < STARVE_LIM)
                    starve_cnt <= starve_cnt + CNT_ONE;
            end else if (in_idle && grant_ifu) begin
                owner      <= OWN_IFU;
                cap_addr   <= ifu_addr;
                cap_wen    <= 1'b0;
                cap_wdata  <= '0;
                cap_wmask  <= '0;
                starve_cnt <= '0;
            end
            // The fetch still completes downstream; only its return is discarded.
            if (resp_fire)
                drop <= 1'b0;
            else if (!in_idle && (owner == OWN_IFU) && ifu_flush)
                drop <= 1'b1;
        end
    end

    always_comb begin
        ifu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;
        ifu_rvalid = 1'b0;
        ifu_rdata  = '0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        busy       = 1'b0;
        if (!rst) begin
            ifu_gnt    = in_idle && grant_ifu;
            lsu_gnt    = in_idle && grant_lsu;
            busy       = !in_idle;
            ifu_rvalid = resp_fire && (owner == OWN_IFU) && !drop && !ifu_flush;
            lsu_rvalid = resp_fire && (owner == OWN_LSU);
            if (ifu_rvalid)
                ifu_rdata = mem_rdata;
            if (lsu_rvalid && !cap_wen)
                lsu_rdata = mem_rdata;
            if (in_req) begin
                mem_req   = 1'b1;
                mem_wen   = cap_wen;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_wmask = cap_wmask;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ifu_req, ifu_flush, ifu_gnt, ifu_rvalid;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req, lsu_wen, lsu_gnt, lsu_rvalid;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]        lsu_wmask;
    logic              mem_req, mem_wen, mem_gnt, mem_rvalid, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [7:0]        mem_wmask;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
        .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one outstanding access, who owns it,
    // whether the memory has accepted it, and how long IFU has been passed over.
    bit          m_busy, m_accepted, m_owner_lsu, m_drop, m_wen;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wmask;
    int          m_streak;
    bit          m_ifu_granted, m_lsu_granted;
    bit          chk_en = 1'b0;

    bit          e_ig, e_lg, e_irv, e_lrv, e_mreq, e_busy, lw, iw, resp;
    logic [63:0] e_ird, e_lrd;

    always @(negedge clk) begin
        if (chk_en) begin
            {e_ig, e_lg, e_irv, e_lrv, e_mreq, e_busy, lw, iw, resp} = '0;
            e_ird = '0;
            e_lrd = '0;
            if (!rst) begin
                if (!m_busy) begin
                    lw = lsu_req && (!ifu_req || m_streak < STARVE_MAX);
                    iw = ifu_req && !lw;
                    e_lg = lw;
                    e_ig = iw;
                end else begin
                    e_busy = 1'b1;
                    e_mreq = !m_accepted;
                    resp   = mem_rvalid && (m_accepted || mem_gnt);
                    e_lrv  = resp && m_owner_lsu;
                    e_irv  = resp && !m_owner_lsu && !m_drop && !ifu_flush;
                    if (e_irv) e_ird = mem_rdata;
                    if (e_lrv && !m_wen) e_lrd = mem_rdata;
                end
            end
            check("busy", busy, e_busy);
            check("ifu_gnt", ifu_gnt, e_ig);
            check("lsu_gnt", lsu_gnt, e_lg);
            check("mem_req", mem_req, e_mreq);
            check("ifu_rvalid", ifu_rvalid, e_irv);
            check("lsu_rvalid", lsu_rvalid, e_lrv);
            check("ifu_rdata", ifu_rdata, e_ird);
            check("lsu_rdata", lsu_rdata, e_lrd);
            check("mem_addr", mem_addr, e_mreq ? m_addr : 64'h0);
            check("mem_wen", mem_wen, e_mreq && m_wen);
            check("mem_wmask", mem_wmask, e_mreq ? m_wmask : 8'h0);
            if (e_mreq && m_wen) check("mem_wdata", mem_wdata, m_wdata);

            m_ifu_granted = e_ig;
            m_lsu_granted = e_lg;
            if (rst) begin
                {m_busy, m_accepted, m_owner_lsu, m_drop, m_wen} = '0;
                m_addr = '0; m_wdata = '0; m_wmask = '0; m_streak = 0;
            end else if (!m_busy) begin
                if (lw || iw) begin
                    m_busy      = 1'b1;
                    m_accepted  = 1'b0;
                    m_drop      = 1'b0;
                    m_owner_lsu = lw;
                    m_addr      = lw ? lsu_addr : ifu_addr;
                    m_wen       = lw && lsu_wen;
                    m_wdata     = lsu_wdata;
                    m_wmask     = lw ? lsu_wmask : 8'h0;
                    if (lw && ifu_req)
                        m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
                    else
                        m_streak = 0;
                end
            end else if (resp) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else begin
                if (mem_gnt) m_accepted = 1'b1;
                if (ifu_flush && !m_owner_lsu) m_drop = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    bit ifu_pend, lsu_pend;

    initial begin
        rst = 1'b1;
        {ifu_req, ifu_flush, lsu_req, lsu_wen, mem_gnt, mem_rvalid} = '0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_rdata = '0;
        chk_en = 1'b1;

        // Reset holds every output low even with requests present.
        step(); ifu_req = 1'b1; lsu_req = 1'b1; at_neg();
        check("rst_ifu_gnt", ifu_gnt, 1'b0);
        check("rst_lsu_gnt", lsu_gnt, 1'b0);
        check("rst_busy", busy, 1'b0);
        step(); ifu_req = 1'b0; lsu_req = 1'b0;
        step(); rst = 1'b0;

        // IFU-only fetch: gnt at t, mem_req at t+1, data at t+2, idle at t+3.
        ifu_req = 1'b1; ifu_addr = 64'h8000_0000; at_neg();
        check("d1_ifu_gnt", ifu_gnt, 1'b1);
        check("d1_lsu_gnt", lsu_gnt, 1'b0);
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; at_neg();
        check("d1_mem_req", mem_req, 1'b1);
        check("d1_mem_addr", mem_addr, 64'h8000_0000);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0010_0093; at_neg();
        check("d1_ifu_rvalid", ifu_rvalid, 1'b1);
        check("d1_ifu_rdata", ifu_rdata, 64'h0010_0093);
        check("d1_mem_req_off", mem_req, 1'b0);
        step(); mem_rvalid = 1'b0; at_neg();
        check("d1_busy_low", busy, 1'b0);

        // Simultaneous requests: LSU load first, IFU in the next IDLE cycle.
        step(); ifu_req = 1'b1; ifu_addr = 64'h8000_0004;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_1000; at_neg();
        check("d2_lsu_gnt", lsu_gnt, 1'b1);
        check("d2_ifu_gnt", ifu_gnt, 1'b0);
        step(); lsu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        mem_rdata = 64'h1122_3344_5566_7788; at_neg();
        check("d2_mem_addr", mem_addr, 64'h8000_1000);
        check("d2_lsu_rvalid", lsu_rvalid, 1'b1);
        check("d2_lsu_rdata", lsu_rdata, 64'h1122_3344_5566_7788);
        check("d2_ifu_rvalid", ifu_rvalid, 1'b0);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0; at_neg();
        check("d2_ifu_gnt_late", ifu_gnt, 1'b1);
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; at_neg();
        check("d2_ifu_rvalid", ifu_rvalid, 1'b1);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // Both held, zero-wait memory: four LSU grants then one IFU grant.
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            check("d3_lsu_gnt", lsu_gnt, (i % 5) != 4);
            check("d3_ifu_gnt", ifu_gnt, (i % 5) == 4);
            step(); mem_gnt = 1'b1; mem_rvalid = 1'b1;
            at_neg();
            step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
        ifu_req = 1'b0; lsu_req = 1'b0;

        // Store with a slow mem_gnt; inputs change under it but mem_* must not.
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_2000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; at_neg();
        check("d4_lsu_gnt", lsu_gnt, 1'b1);
        step(); lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("d4_mem_req", mem_req, 1'b1);
            check("d4_mem_wen", mem_wen, 1'b1);
            check("d4_mem_addr", mem_addr, 64'h8000_2000);
            check("d4_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
            check("d4_mem_wmask", mem_wmask, 8'h0F);
            step();
        end
        mem_gnt = 1'b1; at_neg();
        check("d4_mem_req_gnt", mem_req, 1'b1);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_F00D; at_neg();
        check("d4_lsu_rvalid", lsu_rvalid, 1'b1);
        check("d4_lsu_rdata", lsu_rdata, 64'h0);
        check("d4_ifu_rvalid", ifu_rvalid, 1'b0);
        step(); mem_rvalid = 1'b0;

        // Flush during RESP drops the fetch; the next fetch returns normally.
        ifu_req = 1'b1; ifu_addr = 64'h8000_0100; at_neg();
        check("d5_ifu_gnt", ifu_gnt, 1'b1);
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; at_neg();
        step(); mem_gnt = 1'b0; ifu_flush = 1'b1; at_neg();
        step(); ifu_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD; at_neg();
        check("d5_dropped", ifu_rvalid, 1'b0);
        check("d5_busy", busy, 1'b1);
        step(); mem_rvalid = 1'b0; at_neg();
        check("d5_idle", busy, 1'b0);
        step(); ifu_req = 1'b1; ifu_addr = 64'h8000_0200; at_neg();
        check("d5_refetch_gnt", ifu_gnt, 1'b1);
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h13; at_neg();
        check("d5_refetch_rvalid", ifu_rvalid, 1'b1);
        check("d5_refetch_rdata", ifu_rdata, 64'h13);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0; ifu_req = 1'b1; ifu_addr = 64'h8000_0300;
        at_neg();
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; at_neg();
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; ifu_flush = 1'b1; at_neg();
        check("d5_flush_coincident", ifu_rvalid, 1'b0);
        step(); mem_rvalid = 1'b0; ifu_flush = 1'b0;

        // Reset in RESP; the late response lands in IDLE and is ignored.
        ifu_req = 1'b1; ifu_addr = 64'h8000_0400; at_neg();
        step(); ifu_req = 1'b0; mem_gnt = 1'b1; at_neg();
        step(); mem_gnt = 1'b0; rst = 1'b1; at_neg();
        check("d6_rst_busy", busy, 1'b0);
        check("d6_rst_mem_req", mem_req, 1'b0);
        step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77; at_neg();
        check("d6_ifu_rvalid", ifu_rvalid, 1'b0);
        check("d6_lsu_rvalid", lsu_rvalid, 1'b0);
        check("d6_busy", busy, 1'b0);
        step(); mem_rvalid = 1'b0;

        // Randomized traffic: requesters hold until granted, memory stalls at random.
        ifu_pend = 1'b0;
        lsu_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (m_ifu_granted) ifu_pend = 1'b0;
            if (m_lsu_granted) lsu_pend = 1'b0;
            if (!ifu_pend && $urandom_range(0, 99) < 40) begin
                ifu_pend = 1'b1;
                ifu_addr = {32'h0, $urandom()};
            end
            if (!lsu_pend && $urandom_range(0, 99) < 40) begin
                lsu_pend  = 1'b1;
                lsu_wen   = $urandom_range(0, 1) == 1;
                lsu_addr  = {32'h0, $urandom()};
                lsu_wdata = {$urandom(), $urandom()};
                lsu_wmask = 8'($urandom_range(0, 255));
            end
            ifu_req    = ifu_pend;
            lsu_req    = lsu_pend;
            ifu_flush  = $urandom_range(0, 99) < 10;
            rst        = $urandom_range(0, 199) == 0;
            mem_rdata  = {$urandom(), $urandom()};
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (m_busy && !m_accepted) begin
                mem_gnt    = $urandom_range(0, 99) < 50;
                mem_rvalid = mem_gnt ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
            end else if (m_busy) begin
                mem_rvalid = $urandom_range(0, 99) < 40;
            end else begin
                mem_rvalid = $urandom_range(0, 99) < 5;
            end
        end
        step();
        {ifu_req, lsu_req, ifu_flush, mem_gnt, mem_rvalid, rst} = '0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
